// File: rtl/alu_pkg.sv
// alu_pkg: ALU function selects, flag bit positions and the multiplier FSM state encoding.
package alu_pkg;
    localparam logic [4:0] FS_PASSA16 = 5'b10000;
    localparam logic [4:0] FS_ADD16   = 5'b10100;
    localparam logic [4:0] FS_LSL16   = 5'b11011;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;
    typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHIFT, S_FLAG, S_CAPT} state_t;
endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add unsigned multiplier that borrows the shared 16-bit ALU while Busy.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Multiplicand,
    input  logic [WIDTH-1:0] Multiplier,
    output logic             Busy,
    output logic             Done,
    output logic [15:0]      Product,
    output logic             ProductZero,
    output logic             ProductNeg,
    output logic [15:0]      AluA,
    output logic [15:0]      AluB,
    output logic [4:0]       AluFunSel,
    output logic             AluWF,
    input  logic [15:0]      AluOut,
    input  logic [3:0]       AluFlags
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [15:0]       p_q, p_d, m_q, m_d, product_q, product_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [CW-1:0]     count_q, count_d;
    logic              busy_q, busy_d, done_q, done_d, zero_q, zero_d, neg_q, neg_d;
    logic              unused_flags;

    assign unused_flags = ^{AluFlags[FLAG_C], AluFlags[FLAG_O]};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        case (state_q)
            S_IDLE:  state_d = Start ? S_ADD : S_IDLE;
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: state_d = (count_q == LAST) ? S_FLAG : S_ADD;
            S_FLAG:  state_d = S_CAPT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        AluFunSel = FS_PASSA16;
        AluA      = '0;
        AluB      = '0;
        AluWF     = 1'b0;
        case (state_q)
            S_ADD:   begin AluFunSel = FS_ADD16; AluA = p_q; AluB = m_q; end
            S_SHIFT: begin AluFunSel = FS_LSL16; AluA = m_q; end
            S_FLAG:  begin AluA = p_q; AluWF = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        p_d       = p_q;
        m_d       = m_q;
        q_d       = q_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        case (state_q)
            S_IDLE: if (Start) begin
                p_d     = '0;
                m_d     = 16'(Multiplicand);
                q_d     = Multiplier;
                count_d = '0;
                busy_d  = 1'b1;
            end
            S_ADD:   p_d = q_q[0] ? AluOut : p_q;
            S_SHIFT: begin
                m_d     = AluOut;
                q_d     = q_q >> 1;
                count_d = count_q + 1'b1;
            end
            // flags were written by the ALU at the end of FLAG, so they describe P here
            S_CAPT: begin
                product_d = p_q;
                zero_d    = AluFlags[FLAG_Z];
                neg_d     = AluFlags[FLAG_N];
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            p_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            p_q       <= p_d;
            m_q       <= m_d;
            q_q       <= q_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Product     = product_q;
    assign ProductZero = zero_q;
    assign ProductNeg  = neg_q;
endmodule
